// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_pkg
// Brief   : Shared read-mode constants and pointer helpers for the FIFO family
// Revision: 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int fifo_ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Wraps at depth-1 so non-power-of-2 depths never address a missing entry
    function automatic int unsigned fifo_next_ptr(input int unsigned ptr,
                                                  input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// Module  : fifo_mem
// Brief   : WIDTH x DEPTH register file, one sync write port, one async read
// Revision: 1.0 - initial release
// ============================================================================
module fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [PTR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [PTR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_flags.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo_flags
// Brief   : Single-clock FIFO, any depth, FWFT/registered read, level flags
// Revision: 1.0 - initial release
// ============================================================================
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 3,
    parameter int FWFT      = 1,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = 1,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             w_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic             r_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             r_valid,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam int c_ptr_w = fifo_ptr_w(DEPTH);

    if ((AFULL_TH > DEPTH) || (AFULL_TH < 0)) begin : g_bad_afull_th
        $error("sync_fifo_flags: AFULL_TH must lie in 0..DEPTH");
    end
    if ((AEMPTY_TH >= DEPTH) || (AEMPTY_TH < 0)) begin : g_bad_aempty_th
        $error("sync_fifo_flags: AEMPTY_TH must lie in 0..DEPTH-1");
    end

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;
    logic               r_underflow;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [WIDTH-1:0]   w_rd_data;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    // No ready-through: a pop in the same cycle never frees room for a full FIFO
    assign w_push  = w_valid && !w_full;
    assign w_pop   = r_ready && !w_empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= c_ptr_w'(fifo_next_ptr(32'(r_wr_ptr), DEPTH));
            end
            if (w_pop) begin
                r_rd_ptr <= c_ptr_w'(fifo_next_ptr(32'(r_rd_ptr), DEPTH));
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_valid && w_full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (r_ready && w_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (c_ptr_w)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_in),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign data_out = w_rd_data;
        assign r_valid  = !w_empty;
    end else begin : g_reg_read
        logic [WIDTH-1:0] r_dout;
        logic             r_rvalid;

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_dout   <= '0;
                r_rvalid <= 1'b0;
            end else begin
                r_rvalid <= w_pop;
                if (w_pop) begin
                    r_dout <= w_rd_data;
                end
            end
        end

        assign data_out = r_dout;
        assign r_valid  = r_rvalid;
    end

    assign count        = r_count;
    assign fifo_full    = w_full;
    assign fifo_empty   = w_empty;
    assign almost_full  = (int'(r_count) >= AFULL_TH);
    assign almost_empty = (int'(r_count) <= AEMPTY_TH);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flags.sv
`default_nettype none
// ============================================================================
// Module  : tb_sync_fifo_flags
// Brief   : Self-checking bench; three FIFO configurations share one stimulus
// Revision: 1.0 - initial release
// ============================================================================
module tb_sync_fifo_flags;

    localparam int NI = 3;

    logic        clk;
    logic        rst_n;
    logic        wv;
    logic [31:0] din;
    logic        rr;
    logic        clr;

    // Instance 0: DEPTH=3 FWFT; 1: DEPTH=5 FWFT; 2: DEPTH=3 registered read
    logic [31:0] a_dout, b_dout, c_dout;
    logic        a_rv, b_rv, c_rv, a_full, b_full, c_full, a_empty, b_empty, c_empty;
    logic        a_af, b_af, c_af, a_ae, b_ae, c_ae;
    logic        a_ovf, b_ovf, c_ovf, a_unf, b_unf, c_unf;
    logic [1:0]  a_cnt, c_cnt;
    logic [2:0]  b_cnt;

    sync_fifo_flags #(.WIDTH(32), .DEPTH(3), .FWFT(1)) u_a (
        .clk(clk), .reset(rst_n), .w_valid(wv), .data_in(din), .r_ready(rr),
        .data_out(a_dout), .r_valid(a_rv), .fifo_full(a_full), .fifo_empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .count(a_cnt),
        .overflow(a_ovf), .underflow(a_unf), .clr_err(clr));

    sync_fifo_flags #(.WIDTH(32), .DEPTH(5), .FWFT(1)) u_b (
        .clk(clk), .reset(rst_n), .w_valid(wv), .data_in(din), .r_ready(rr),
        .data_out(b_dout), .r_valid(b_rv), .fifo_full(b_full), .fifo_empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt),
        .overflow(b_ovf), .underflow(b_unf), .clr_err(clr));

    sync_fifo_flags #(.WIDTH(32), .DEPTH(3), .FWFT(0)) u_c (
        .clk(clk), .reset(rst_n), .w_valid(wv), .data_in(din), .r_ready(rr),
        .data_out(c_dout), .r_valid(c_rv), .fifo_full(c_full), .fifo_empty(c_empty),
        .almost_full(c_af), .almost_empty(c_ae), .count(c_cnt),
        .overflow(c_ovf), .underflow(c_unf), .clr_err(clr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] dout;
        logic        rv, full, empty, af, ae, ovf, unf;
        logic [2:0]  cnt;
    } obs_t;

    typedef struct {
        bit          rst_n, wv;
        logic [31:0] din;
        bit          rr, clr;
        int          e_cnt;
        bit          e_full, e_empty, e_af, e_ae, e_ovf, e_unf, e_rv, chk_dout;
        logic [31:0] e_dout;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: occupancy is simply the queue length
    logic [31:0] mq [NI][$];
    logic        m_ovf [NI];
    logic        m_unf [NI];
    logic        m_rv  [NI];
    logic [31:0] m_dout[NI];

    function automatic int dep(input int k);
        return (k == 1) ? 5 : 3;
    endfunction

    function automatic bit is_fwft(input int k);
        return (k != 2);
    endfunction

    function automatic obs_t get_obs(input int k);
        obs_t o;
        case (k)
            0:       o = '{a_dout, a_rv, a_full, a_empty, a_af, a_ae, a_ovf, a_unf, {1'b0, a_cnt}};
            1:       o = '{b_dout, b_rv, b_full, b_empty, b_af, b_ae, b_ovf, b_unf, b_cnt};
            default: o = '{c_dout, c_rv, c_full, c_empty, c_af, c_ae, c_ovf, c_unf, {1'b0, c_cnt}};
        endcase
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        int d = dep(k);
        int n = mq[k].size();
        bit full  = (n == d);
        bit empty = (n == 0);
        if (!rst_n) begin
            mq[k].delete();
            m_ovf[k]  = 1'b0;
            m_unf[k]  = 1'b0;
            m_rv[k]   = 1'b0;
            m_dout[k] = '0;
            return;
        end
        if (wv && full)     m_ovf[k] = 1'b1;
        else if (clr)       m_ovf[k] = 1'b0;
        if (rr && empty)    m_unf[k] = 1'b1;
        else if (clr)       m_unf[k] = 1'b0;
        if (!is_fwft(k)) begin
            m_rv[k] = rr && !empty;
            if (rr && !empty) m_dout[k] = mq[k][0];
        end
        if (rr && !empty) void'(mq[k].pop_front());
        if (wv && !full)  mq[k].push_back(din);
    endtask

    task automatic check_model(input int k);
        obs_t  o = get_obs(k);
        int    n = mq[k].size();
        int    d = dep(k);
        string p = $sformatf("model.u%0d", k);
        chk({p, ".count"}, 32'(o.cnt), 32'(n));
        chk({p, ".full"},  32'(o.full),  32'(n == d));
        chk({p, ".empty"}, 32'(o.empty), 32'(n == 0));
        chk({p, ".afull"}, 32'(o.af),    32'(n >= d - 1));
        chk({p, ".aempty"}, 32'(o.ae),   32'(n <= 1));
        chk({p, ".ovf"},   32'(o.ovf),   32'(m_ovf[k]));
        chk({p, ".unf"},   32'(o.unf),   32'(m_unf[k]));
        if (is_fwft(k)) begin
            chk({p, ".rvalid"}, 32'(o.rv), 32'(n != 0));
            if (n != 0) chk({p, ".dout"}, o.dout, mq[k][0]);
        end else begin
            chk({p, ".rvalid"}, 32'(o.rv), 32'(m_rv[k]));
            chk({p, ".dout"},   o.dout,    m_dout[k]);
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check #1 later
    task automatic step(input logic r, input logic w, input logic [31:0] d,
                        input logic rd, input logic c);
        rst_n = r; wv = w; din = d; rr = rd; clr = c;
        @(posedge clk);
        for (int k = 0; k < NI; k++) model_step(k);
        #1;
        for (int k = 0; k < NI; k++) check_model(k);
    endtask

    vec_t tv[20];

    initial begin
        tv[0]  = '{0, 0, 32'h0,  0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 32'h0};
        tv[1]  = '{1, 0, 32'h0,  0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 32'h0};
        tv[2]  = '{1, 1, 32'h0,  0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1, 32'h0};
        tv[3]  = '{1, 1, 32'h1,  0, 0, 2, 0, 0, 1, 0, 0, 0, 1, 1, 32'h0};
        tv[4]  = '{1, 1, 32'h2,  0, 0, 3, 1, 0, 1, 0, 0, 0, 1, 1, 32'h0};
        tv[5]  = '{1, 1, 32'h3,  0, 0, 3, 1, 0, 1, 0, 1, 0, 1, 1, 32'h0};
        tv[6]  = '{1, 0, 32'h0,  1, 0, 2, 0, 0, 1, 0, 1, 0, 1, 1, 32'h1};
        tv[7]  = '{1, 0, 32'h0,  1, 0, 1, 0, 0, 0, 1, 1, 0, 1, 1, 32'h2};
        tv[8]  = '{1, 0, 32'h0,  1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 32'h0};
        tv[9]  = '{1, 0, 32'h0,  1, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0, 32'h0};
        tv[10] = '{1, 0, 32'h0,  0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 32'h0};
        tv[11] = '{1, 1, 32'h55, 1, 0, 1, 0, 0, 0, 1, 0, 1, 1, 1, 32'h55};
        tv[12] = '{1, 1, 32'h66, 1, 1, 1, 0, 0, 0, 1, 0, 0, 1, 1, 32'h66};
        tv[13] = '{1, 1, 32'h77, 0, 0, 2, 0, 0, 1, 0, 0, 0, 1, 1, 32'h66};
        tv[14] = '{1, 1, 32'h88, 1, 0, 2, 0, 0, 1, 0, 0, 0, 1, 1, 32'h77};
        tv[15] = '{1, 1, 32'h99, 0, 0, 3, 1, 0, 1, 0, 0, 0, 1, 1, 32'h77};
        tv[16] = '{1, 1, 32'hAA, 1, 0, 2, 0, 0, 1, 0, 1, 0, 1, 1, 32'h88};
        tv[17] = '{1, 1, 32'hBB, 0, 1, 3, 1, 0, 1, 0, 0, 0, 1, 1, 32'h88};
        tv[18] = '{1, 1, 32'hCC, 0, 1, 3, 1, 0, 1, 0, 1, 0, 1, 1, 32'h88};
        tv[19] = '{0, 1, 32'hDD, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 32'h0};

        for (int i = 0; i < 20; i++) begin
            string p = $sformatf("vec%0d", i);
            step(tv[i].rst_n, tv[i].wv, tv[i].din, tv[i].rr, tv[i].clr);
            chk({p, ".count"},  32'(a_cnt),   32'(tv[i].e_cnt));
            chk({p, ".full"},   32'(a_full),  32'(tv[i].e_full));
            chk({p, ".empty"},  32'(a_empty), 32'(tv[i].e_empty));
            chk({p, ".afull"},  32'(a_af),    32'(tv[i].e_af));
            chk({p, ".aempty"}, 32'(a_ae),    32'(tv[i].e_ae));
            chk({p, ".ovf"},    32'(a_ovf),   32'(tv[i].e_ovf));
            chk({p, ".unf"},    32'(a_unf),   32'(tv[i].e_unf));
            chk({p, ".rvalid"}, 32'(a_rv),    32'(tv[i].e_rv));
            if (tv[i].chk_dout) chk({p, ".dout"}, a_dout, tv[i].e_dout);
        end

        // Pointer wrap on DEPTH=5 with push+pop held at count 2
        step(0, 0, 0, 0, 0);
        step(1, 1, 32'd1, 0, 0);
        step(1, 1, 32'd2, 0, 0);
        for (int v = 3; v <= 7; v++) begin
            step(1, 1, 32'(v), 1, 0);
            chk("wrap.count", 32'(b_cnt), 32'd2);
            chk("wrap.dout",  b_dout,     32'(v - 1));
        end
        step(1, 0, 0, 1, 0);
        chk("wrap.tail_dout", b_dout, 32'd7);
        step(1, 0, 0, 1, 0);
        chk("wrap.drained", 32'(b_empty), 32'd1);

        // Registered read: one-cycle latency, data holds after r_valid drops
        step(0, 0, 0, 0, 0);
        step(1, 1, 32'hA5A5A5A5, 0, 0);
        chk("regrd.pre_rvalid", 32'(c_rv), 32'd0);
        chk("regrd.pre_dout",   c_dout,    32'd0);
        step(1, 0, 0, 1, 0);
        chk("regrd.rvalid", 32'(c_rv), 32'd1);
        chk("regrd.dout",   c_dout,    32'hA5A5A5A5);
        step(1, 0, 0, 0, 0);
        chk("regrd.rvalid_drop", 32'(c_rv), 32'd0);
        chk("regrd.dout_hold",   c_dout,    32'hA5A5A5A5);

        // Reset with data stored must discard it
        step(1, 1, 32'h11111111, 0, 0);
        step(1, 1, 32'h22222222, 0, 0);
        chk("midrst.pre_count", 32'(a_cnt), 32'd2);
        step(0, 0, 0, 0, 0);
        chk("midrst.count", 32'(a_cnt),   32'd0);
        chk("midrst.empty", 32'(a_empty), 32'd1);
        step(1, 1, 32'hDEADBEEF, 0, 0);
        chk("midrst.fwft_dout", a_dout, 32'hDEADBEEF);
        step(1, 0, 0, 1, 0);
        chk("midrst.reg_dout", c_dout, 32'hDEADBEEF);

        // Randomised traffic: write-heavy then read-heavy phases
        for (int i = 0; i < 600; i++) begin
            int wp = (i < 300) ? 70 : 35;
            step($urandom_range(0, 79) != 0,
                 $urandom_range(0, 99) < wp,
                 $urandom,
                 $urandom_range(0, 99) < (100 - wp),
                 $urandom_range(0, 15) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised successor to the team's single-clock `fifo`. It keeps the valid/ready push-pop interface and the full/empty flags. It adds:
- arbitrary (non-power-of-2) depth,
- selectable first-word-fall-through or registered read mode,
- an occupancy count,
- programmable almost-full and almost-empty thresholds,
- sticky overflow/underflow error flags.

It sits between SoC stream producers and consumers as the standard elastic buffer.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 3, number of entries (>=2; any integer, not restricted to powers of 2)
FWFT, 1, read mode: 1 = first-word-fall-through, 0 = registered read (1-cycle latency)
AFULL_TH, DEPTH-1, almost_full asserted when count >= AFULL_TH
AEMPTY_TH, 1, almost_empty asserted when count <= AEMPTY_TH
CNT_W, $clog2(DEPTH+1), width of count

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  one clock; reset is synchronous and active-low
w_valid  in  1  producer has data_in valid
data_in  in  WIDTH  write data
r_ready  in  1  consumer requests/accepts a word
data_out  out  WIDTH  read data
r_valid  out  1  data_out valid (mode-dependent, see below)
fifo_full  out  1  count == DEPTH
fifo_empty  out  1  count == 0
almost_full  out  1  count >= AFULL_TH
almost_empty  out  1  count <= AEMPTY_TH
count  out  CNT_W  current occupancy
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
clr_err  in  1  clears overflow/underflow

Behaviour:
- Reset (reset==0 at a clk edge):
  - wr_ptr=rd_ptr=0, count=0, fifo_empty=1, fifo_full=0.
  - almost_empty=1, almost_full=(AFULL_TH==0).
  - overflow=underflow=0, r_valid=0, data_out=0 (FWFT=0).
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data; the next cycle behaves as empty.
- Push: a write is accepted when w_valid && !fifo_full. mem[wr_ptr]<=data_in; wr_ptr advances.
- Pop: a read is accepted when r_ready && !fifo_empty. rd_ptr advances.
- Pointer wrap: a pointer at DEPTH-1 goes to 0. There is no extra wrap bit; count disambiguates full from empty.
- count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Flags: all flags are combinational decodes of the count register, so they update the cycle after the accepting edge.
- Simultaneous push and pop:
  - Full: the write is rejected even if a read occurs in the same cycle (no ready-through path). overflow is set if w_valid.
  - Empty: the read is rejected and underflow is set; the write is accepted.
  - Otherwise: both are accepted and count is unchanged.
- Sticky errors: overflow sets on w_valid && fifo_full; underflow sets on r_ready && fifo_empty. Set has priority over clr_err in the same cycle.
- FWFT=1:
  - data_out = mem[rd_ptr] combinationally; r_valid = !fifo_empty.
  - The word is consumed at the edge where r_ready && r_valid.
- FWFT=0:
  - On an accepted read, data_out<=mem[rd_ptr] and r_valid<=1 at the same edge. The word is visible the cycle after the request.
  - r_valid<=0 when no read is accepted; data_out holds its last value.
- Thresholds: at elaboration, AFULL_TH must be <= DEPTH and AEMPTY_TH must be < DEPTH. Illegal values trigger $error.

Decomposition:
- Shared package fifo_pkg:
  - mode constants FIFO_MODE_REG=0 and FIFO_MODE_FWFT=1,
  - a function for pointer/count width,
  - a next-pointer-with-wrap function taking DEPTH.
- One sub-module, fifo_mem: WIDTH x DEPTH register file with 1 sync write port and 1 async read port. Mode muxing, pointers, count and flags stay in sync_fifo_flags.

Test Plan:
1. Reset check (DEPTH=3, FWFT=1): hold reset low 1 cycle, release -> fifo_empty=1, count=0, almost_empty=1, r_valid=0, overflow=underflow=0.
2. Fill to full: push 0,1,2 -> count 1,2,3. almost_full at count 2, fifo_full at 3. A 4th push of 3 -> rejected, overflow=1, count stays 3.
3. FWFT drain order: from full, hold r_ready 3 cycles -> data_out 0,1,2 in order, count back to 0. A 4th r_ready -> underflow=1, data_out not consumed. clr_err -> both sticky flags clear.
4. Wrap with DEPTH=5: push 7 and pop 7 interleaved, with simultaneous push+pop at count=2 -> count stays 2, output order matches input order across pointer wrap 4->0.
5. Registered mode (FWFT=0, DEPTH=3): push A5A5A5A5, then pulse r_ready -> next cycle r_valid=1 and data_out=A5A5A5A5. The following cycle r_valid=0 and data_out holds.
6. Reset mid-operation: with count=2, assert reset -> next cycle count=0 and fifo_empty=1. A new push of 0xDEADBEEF then reads back 0xDEADBEEF, not stale data.
